slicel_cfg_loader: RTL and testbench
====================================

SLICEL_CFG_LOADER -- requirements
Module: slicel_cfg_loader

Interface
REQ-001 The block SHALL have parameter S_XX_BASE, default 4, LUT input count per half-LUT.
REQ-002 The block SHALL have parameter NUM_LUTS, default 4, LUTs per slice (power of 2).
REQ-003 The block SHALL have parameter WORD_W, default 8, config stream word width.
REQ-004 The block SHALL derive CFG_SIZE = 2*2**S_XX_BASE+1, MUX_LVLS = clog2(NUM_LUTS), CFG_BITS = NUM_LUTS*CFG_SIZE+MUX_LVLS+1 (135), NWORDS = ceil(CFG_BITS/WORD_W) (17).
REQ-005 The block SHALL have ports:
- clk  in  1  single clock; also drives the slice cclk and clk
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load
- abort  in  1  cancel a load
- in_data  in  WORD_W  config word
- in_valid  in  1  word present
- in_ready  out  1  word accepted when in_valid & in_ready
- user_reg_ce  in  1  fabric register enable request
- cfg_luts  out  NUM_LUTS*CFG_SIZE  to slice luts_config_in
- cfg_mux  out  MUX_LVLS  to slice inter_lut_mux_config
- cfg_use_cc  out  1  to slice config_use_cc
- cfg_cen  out  1  to slice cen
- slice_reg_ce  out  1  to slice reg_ce
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse

Function
REQ-006 The block SHALL implement FSM states IDLE, LOAD, COMMIT, DONE.
REQ-007 IDLE->LOAD on start=1, which SHALL clear the word counter; otherwise IDLE SHALL hold.
REQ-008 In LOAD, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-009 Each accepted word k (0..NWORDS-1) SHALL be written to shadow bits [k*WORD_W +: WORD_W]; shadow bits at or above CFG_BITS SHALL be discarded.
REQ-010 Shadow packing SHALL be: bits [NUM_LUTS*CFG_SIZE-1:0] -> cfg_luts, next MUX_LVLS bits -> cfg_mux, bit CFG_BITS-1 -> cfg_use_cc.
REQ-011 Accepting word NWORDS-1 SHALL move LOAD->COMMIT on the next edge.
REQ-012 cfg_luts/cfg_mux/cfg_use_cc SHALL be driven directly from registered shadow, so they are stable during the COMMIT cycle.
REQ-013 cfg_cen SHALL be 1 for exactly the one cycle spent in COMMIT, otherwise 0.
REQ-014 COMMIT->DONE unconditionally; done SHALL be 1 for exactly the one cycle in DONE; DONE->IDLE unconditionally.
REQ-015 busy SHALL be 1 in LOAD, COMMIT and DONE, 0 in IDLE.
REQ-016 slice_reg_ce SHALL equal user_reg_ce & ~busy.
REQ-017 start while busy SHALL be ignored.
REQ-018 abort in LOAD SHALL return to IDLE next edge, with no cfg_cen and no done; abort has priority over a simultaneous word acceptance (word discarded).
REQ-019 abort in COMMIT or DONE SHALL be ignored.
REQ-020 start and abort together in IDLE SHALL enter LOAD.
REQ-021 in_valid gaps in LOAD SHALL stall the counter without timeout.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state IDLE, counter 0, shadow all 0, in_ready 0, cfg_cen 0, done 0, busy 0.
REQ-023 Reset mid-LOAD or in COMMIT SHALL cancel the load; no cfg_cen pulse SHALL follow reset release.

Structure
REQ-024 CFG_SIZE/MUX_LVLS/CFG_BITS/NWORDS derivations and the FSM state encoding SHALL live in a shared package slice_cfg_pkg.
REQ-025 No sub-module is required; an optional slicel_cfg_shadow (word-indexed shadow register) MAY be factored out.

Verification
REQ-026 Default params, start, 17 words 0x01..0x11 back-to-back -> in_ready 17 cycles, COMMIT 1 cycle later, cfg_cen=1 one cycle, cfg_luts[7:0]=0x01, cfg_use_cc=bit 134 = bit 6 of 0x11 = 0, done one cycle later, busy 0 after.
REQ-027 Same load with in_valid toggling every other cycle -> identical outputs, cfg_cen 34-35 cycles after start.
REQ-028 abort asserted with word 9 valid -> word 9 not stored, IDLE next cycle, no cfg_cen, no done; new load then succeeds.
REQ-029 user_reg_ce=1 throughout a load -> slice_reg_ce=0 from LOAD entry through DONE, 1 in IDLE.
REQ-030 rst_n low at word 5 -> outputs zero immediately; after release no cfg_cen until a fresh 17-word load.
REQ-031 start pulsed during LOAD word 3 -> no restart; counter continues to word 16.

Source files
------------

// File: rtl/slice_cfg_pkg.sv
// Shared derivations and FSM encoding for the slice configuration loader.
// Geometry helpers take the loader parameters so every user derives identical sizes.
package slice_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DONE   = 2'd3
   } cfg_state_e;

   function automatic int cfg_size(input int s_xx_base);
      return 2 * (2 ** s_xx_base) + 1;
   endfunction

   function automatic int mux_lvls(input int num_luts);
      return $clog2(num_luts);
   endfunction

   // LUT payload, inter-LUT mux selects, then the carry-chain enable on top.
   function automatic int cfg_bits(input int s_xx_base, input int num_luts);
      return num_luts * cfg_size(s_xx_base) + mux_lvls(num_luts) + 1;
   endfunction

   function automatic int nwords(input int s_xx_base, input int num_luts, input int word_w);
      return (cfg_bits(s_xx_base, num_luts) + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/slicel_cfg_loader.sv
// Streams a SLICEL configuration in WORD_W-bit words into a shadow register,
// then pulses the slice config enable for one cycle and reports completion.
module slicel_cfg_loader
   import slice_cfg_pkg::*;
#(
   parameter int S_XX_BASE = 4,
   parameter int NUM_LUTS  = 4,
   parameter int WORD_W    = 8
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         start,
   input  logic                                         abort,
   input  logic [WORD_W-1:0]                            in_data,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic                                         user_reg_ce,
   output logic [NUM_LUTS*cfg_size(S_XX_BASE)-1:0]      cfg_luts,
   output logic [mux_lvls(NUM_LUTS)-1:0]                cfg_mux,
   output logic                                         cfg_use_cc,
   output logic                                         cfg_cen,
   output logic                                         slice_reg_ce,
   output logic                                         busy,
   output logic                                         done
);

   localparam int CFG_SIZE = cfg_size(S_XX_BASE);
   localparam int MUX_LVLS = mux_lvls(NUM_LUTS);
   localparam int CFG_BITS = cfg_bits(S_XX_BASE, NUM_LUTS);
   localparam int NWORDS   = nwords(S_XX_BASE, NUM_LUTS, WORD_W);
   localparam int LUT_BITS = NUM_LUTS * CFG_SIZE;
   localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

   cfg_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CFG_BITS-1:0]  shadow_q, shadow_d;
   logic                 accept;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      accept   = 1'b0;
      in_ready = 1'b0;
      cfg_cen  = 1'b0;
      done     = 1'b0;
      busy     = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            // Abort wins over a word arriving in the same cycle.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (in_valid) begin
               accept = 1'b1;
               if (cnt_q == LAST_WORD) begin
                  state_d = ST_COMMIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_COMMIT: begin
            cfg_cen = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Padding bits of the final word fall beyond CFG_BITS and are dropped.
      for (int i = 0; i < CFG_BITS; i++) begin
         if (accept && (cnt_q == CNT_W'(i / WORD_W))) begin
            shadow_d[i] = in_data[i % WORD_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign cfg_luts     = shadow_q[LUT_BITS-1:0];
   assign cfg_mux      = shadow_q[LUT_BITS +: MUX_LVLS];
   assign cfg_use_cc   = shadow_q[CFG_BITS-1];
   assign slice_reg_ce = user_reg_ce & ~busy;

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Scoreboard bench for slicel_cfg_loader: the driver predicts each committed
// configuration and the cycle-level handshake, a negedge monitor checks both.
module tb_slicel_cfg_loader;
   import slice_cfg_pkg::*;

   localparam int S  = 4;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CS = 2 * 16 + 1;
   localparam int ML = 2;
   localparam int CB = N * CS + ML + 1;
   localparam int NW = (CB + W - 1) / W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          user_reg_ce = 1'b0;
   logic [N*CS-1:0] cfg_luts;
   logic [ML-1:0] cfg_mux;
   logic          cfg_use_cc;
   logic          cfg_cen;
   logic          slice_reg_ce;
   logic          busy;
   logic          done;

   slicel_cfg_loader #(.S_XX_BASE(S), .NUM_LUTS(N), .WORD_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .user_reg_ce(user_reg_ce), .cfg_luts(cfg_luts), .cfg_mux(cfg_mux),
      .cfg_use_cc(cfg_use_cc), .cfg_cen(cfg_cen), .slice_reg_ce(slice_reg_ce),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference: configuration image as the concatenation of accepted words.
   logic [CB-1:0] shadow_m;
   logic [CB-1:0] exp_q[$];
   logic [CB-1:0] e_cfg;
   logic exp_busy = 1'b0, exp_ready = 1'b0, exp_cen = 1'b0, exp_done = 1'b0;
   logic mon_en = 1'b0;

   task automatic chk1(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [CB-1:0] act, input logic [CB-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic put_word(input int k, input logic [W-1:0] d);
      for (int b = 0; b < W; b++)
         if (k * W + b < CB) shadow_m[k*W+b] = d[b];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start       = 1'b0;
         abort       = 1'($urandom_range(0, 1));
         in_valid    = 1'($urandom_range(0, 1));
         in_data     = W'($urandom);
         user_reg_ce = 1'($urandom_range(0, 1));
         tick();
      end
      abort    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic check_all_zero();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_cfg_cen", cfg_cen, 1'b0);
      chk1("rst_done", done, 1'b0);
      chkw("rst_cfg", {cfg_use_cc, cfg_mux, cfg_luts}, '0);
   endtask

   // vmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
   task automatic load(input int vmode, input int abort_at, input int start_at,
                       input int rst_at, input bit seq);
      int k;
      int c;
      start       = 1'b1;
      abort       = 1'($urandom_range(0, 1));
      in_valid    = 1'($urandom_range(0, 1));
      in_data     = W'($urandom);
      user_reg_ce = 1'($urandom_range(0, 1));
      tick();
      start     = 1'b0;
      abort     = 1'b0;
      exp_busy  = 1'b1;
      exp_ready = 1'b1;
      k = 0;
      c = 0;
      while (k < NW) begin
         if (k == rst_at) begin
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            check_all_zero();
            shadow_m  = '0;
            exp_busy  = 1'b0;
            exp_ready = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
            return;
         end
         user_reg_ce = 1'($urandom_range(0, 1));
         start       = (k == start_at);
         in_data     = seq ? W'(k + 1) : W'($urandom);
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = (c % 2 == 0);
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         c++;
         abort = 1'b0;
         if (k == abort_at) begin
            in_valid = 1'b1;
            abort    = 1'b1;
         end
         tick();
         if (abort) begin
            abort     = 1'b0;
            in_valid  = 1'b0;
            start     = 1'b0;
            exp_busy  = 1'b0;
            exp_ready = 1'b0;
            return;
         end
         if (in_valid) begin
            put_word(k, in_data);
            k++;
         end
      end
      in_valid  = 1'b0;
      start     = 1'($urandom_range(0, 1));
      abort     = 1'($urandom_range(0, 1));
      exp_q.push_back(shadow_m);
      exp_ready = 1'b0;
      exp_cen   = 1'b1;
      tick();
      start    = 1'($urandom_range(0, 1));
      abort    = 1'($urandom_range(0, 1));
      exp_cen  = 1'b0;
      exp_done = 1'b1;
      tick();
      start    = 1'b0;
      abort    = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk1("busy", busy, exp_busy);
         chk1("in_ready", in_ready, exp_ready);
         chk1("cfg_cen", cfg_cen, exp_cen);
         chk1("done", done, exp_done);
         chk1("slice_reg_ce", slice_reg_ce, user_reg_ce & ~exp_busy);
         if (cfg_cen) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_commit: cfg_cen=1 with no load pending at %0t", $time);
            end else begin
               e_cfg = exp_q.pop_front();
               chkw("commit_cfg", {cfg_use_cc, cfg_mux, cfg_luts}, e_cfg);
            end
         end
      end
   end

   initial begin
      int ab, st;
      shadow_m = '0;
      #2;
      check_all_zero();
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      idle(3);

      load(0, -1, -1, -1, 1'b1);
      chkw("luts_byte0", CB'(cfg_luts[7:0]), CB'(8'h01));
      chk1("use_cc_bit134", cfg_use_cc, 1'b0);
      chkw("mux_from_word16", CB'(cfg_mux), CB'(2'b01));
      idle(2);

      load(1, -1, -1, -1, 1'b1);
      idle(2);
      load(0, 9, -1, -1, 1'b1);
      idle(1);
      load(0, -1, -1, -1, 1'b1);
      idle(2);
      load(2, -1, 3, -1, 1'b0);
      idle(2);
      load(2, -1, -1, 5, 1'b0);
      idle(6);
      load(2, -1, -1, -1, 1'b0);
      idle(2);

      for (int i = 0; i < 30; i++) begin
         ab = ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, NW - 1)) : -1;
         st = ($urandom_range(0, 99) < 30) ? int'($urandom_range(0, NW - 1)) : -1;
         load(int'($urandom_range(0, 2)), ab, st, -1, 1'b0);
         idle(int'($urandom_range(0, 3)));
      end

      idle(4);
      mon_en = 1'b0;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_commits: %0d left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
